// File: rtl/edge_counter_pkg.sv
// Shared types for the edge counter bank: edge-mode encodings and arming FSM states.
// Build option EDGE_COUNTER_SATURATE_EN (used in edge_channel) selects saturating counters.
package edge_counter_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_e;

  typedef enum logic {
    ARM_ST = 1'b0,
    RUN_ST = 1'b1
  } arm_state_e;

  // Wide enough to count up to the deepest synchroniser (4 stages)
  localparam int ARM_CNT_W = 3;

  function automatic int selWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_channel.sv
// One counter-bank channel: synchroniser, edge history/qualify, event counter and sticky overflow.
// EDGE_COUNTER_SATURATE_EN defined: counter sticks at all-ones; otherwise it wraps to zero.
module edge_channel
  import edge_counter_pkg::*;
#(
  parameter int BITS        = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            Clk,
  input  logic            nReset,
  input  logic            signal_i,
  input  edge_mode_e      edgeMode_i,
  input  logic            run_i,
  input  logic            enable_i,
  input  logic            clear_i,
  output logic            pulse_o,
  output logic [BITS-1:0] count_o,
  output logic            overflow_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   history_q;
  logic                   pulse_q;
  logic [BITS-1:0]        count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   syncLast;
  logic                   edgeHit;
  logic                   countEvent;

  assign syncLast   = sync_q[SYNC_STAGES-1];
  assign countEvent = run_i & enable_i & edgeHit;

  always_comb begin
    edgeHit = 1'b0;
    case (edgeMode_i)
      EDGE_RISE: edgeHit = syncLast & ~history_q;
      EDGE_FALL: edgeHit = ~syncLast & history_q;
      EDGE_BOTH: edgeHit = syncLast ^ history_q;
      default:   edgeHit = 1'b0;
    endcase
  end

  // Clear outranks a same-cycle event, so it also wins over a fresh overflow
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (countEvent) begin
      if (&count_q) begin
        overflow_d = 1'b1;
`ifdef EDGE_COUNTER_SATURATE_EN
        count_d    = count_q;
`else
        count_d    = '0;
`endif
      end else begin
        count_d = count_q + BITS'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      sync_q     <= '0;
      history_q  <= 1'b0;
      pulse_q    <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], signal_i};
      history_q  <= syncLast;
      pulse_q    <= run_i & edgeHit;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign pulse_o    = pulse_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/edge_counter_bank.sv
// Multi-channel edge counter bank: arming FSM, per-channel counters, atomic shadow snapshot and read mux.
// Build option EDGE_COUNTER_SATURATE_EN selects saturating instead of wrapping counters.
module edge_counter_bank
  import edge_counter_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int BITS        = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          Clk,
  input  logic                          nReset,
  input  logic [CHANNELS-1:0]           Signals,
  input  logic [1:0]                    EdgeMode,
  input  logic                          Enable,
  input  logic                          Clear,
  input  logic                          Latch,
  input  logic [selWidth(CHANNELS)-1:0] Sel,
  output logic [BITS-1:0]               Count,
  output logic [CHANNELS-1:0]           Pulses,
  output logic [CHANNELS-1:0]           Overflow,
  output logic                          Armed
);

  localparam int SEL_W = selWidth(CHANNELS);

  arm_state_e            state_q;
  logic [ARM_CNT_W-1:0]  armCnt_q;
  logic                  armed_q;
  logic                  runNow;
  logic [BITS-1:0]       chanCount [CHANNELS];
  logic [BITS-1:0]       shadow_q  [CHANNELS];

  assign runNow = (state_q == RUN_ST);

  // Hold detection off until the synchronisers have flushed whatever level was present at reset release
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state_q  <= ARM_ST;
      armCnt_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      armed_q <= runNow;
      case (state_q)
        ARM_ST: begin
          if (armCnt_q == ARM_CNT_W'(SYNC_STAGES)) begin
            state_q <= RUN_ST;
          end else begin
            armCnt_q <= armCnt_q + ARM_CNT_W'(1);
          end
        end
        RUN_ST:  state_q <= RUN_ST;
        default: state_q <= ARM_ST;
      endcase
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : gen_chan
    edge_channel #(
      .BITS        (BITS),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .Clk        (Clk),
      .nReset     (nReset),
      .signal_i   (Signals[c]),
      .edgeMode_i (edge_mode_e'(EdgeMode)),
      .run_i      (runNow),
      .enable_i   (Enable),
      .clear_i    (Clear),
      .pulse_o    (Pulses[c]),
      .count_o    (chanCount[c]),
      .overflow_o (Overflow[c])
    );
  end

  // Snapshot takes the counters' current values, i.e. before this cycle's clear or increment
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      for (int c = 0; c < CHANNELS; c++) shadow_q[c] <= '0;
    end else if (Latch) begin
      for (int c = 0; c < CHANNELS; c++) shadow_q[c] <= chanCount[c];
    end
  end

  always_comb begin
    Count = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (Sel == SEL_W'(c)) Count = shadow_q[c];
    end
  end

  assign Armed = armed_q;

endmodule

// File: tb/tb_edge_counter_bank.sv
// Scoreboard bench for edge_counter_bank: directed scenarios plus random traffic against an event-level model.
// Honours EDGE_COUNTER_SATURATE_EN when predicting overflow behaviour.
module tb_edge_counter_bank;

  localparam int CH    = 5;
  localparam int BW    = 4;
  localparam int SS    = 3;
  localparam int SEL_W = 3;
  localparam int MAXV  = (1 << BW) - 1;

  typedef struct packed {
    logic [CH-1:0] pulses;
    logic [CH-1:0] ovf;
    logic          armed;
    logic [BW-1:0] count;
  } expect_t;

  logic             Clk;
  logic             nReset;
  logic [CH-1:0]    Signals;
  logic [1:0]       EdgeMode;
  logic             Enable;
  logic             Clear;
  logic             Latch;
  logic [SEL_W-1:0] Sel;
  logic [BW-1:0]    Count;
  logic [CH-1:0]    Pulses;
  logic [CH-1:0]    Overflow;
  logic             Armed;

  logic [CH-1:0]    curSig;
  logic [1:0]       curMode;
  logic             curEn;
  logic [SEL_W-1:0] curSel;

  expect_t          expQ [$];
  logic [CH-1:0]    inHist [$];
  int               edgeIdx;
  int               modelCnt    [CH];
  bit               modelOvf    [CH];
  int               modelShadow [CH];
  int               checkCount;
  int               failCount;

  edge_counter_bank #(
    .CHANNELS    (CH),
    .BITS        (BW),
    .SYNC_STAGES (SS)
  ) dut (
    .Clk      (Clk),
    .nReset   (nReset),
    .Signals  (Signals),
    .EdgeMode (EdgeMode),
    .Enable   (Enable),
    .Clear    (Clear),
    .Latch    (Latch),
    .Sel      (Sel),
    .Count    (Count),
    .Pulses   (Pulses),
    .Overflow (Overflow),
    .Armed    (Armed)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drive one cycle of inputs and predict the outputs seen after the following rising edge
  task automatic applyStimulus(input logic rstN, input logic clr, input logic lat);
    expect_t       exp;
    logic [CH-1:0] nowLvl;
    logic [CH-1:0] prevLvl;
    bit            active;
    bit            hit;
    bit            pulse;
    int            e;
    @(negedge Clk);
    nReset   = rstN;
    Signals  = curSig;
    EdgeMode = curMode;
    Enable   = curEn;
    Clear    = clr;
    Latch    = lat;
    Sel      = curSel;
    exp      = '0;
    if (!rstN) begin
      for (int c = 0; c < CH; c++) begin
        modelCnt[c]    = 0;
        modelOvf[c]    = 1'b0;
        modelShadow[c] = 0;
      end
      inHist.delete();
      edgeIdx = 0;
    end else begin
      e = edgeIdx;
      inHist.push_back(curSig);
      nowLvl  = (e >= SS)     ? inHist[e-SS]   : '0;
      prevLvl = (e >= SS + 1) ? inHist[e-SS-1] : '0;
      active  = (e >= SS + 1);
      for (int c = 0; c < CH; c++) begin
        case (curMode)
          2'b00:   hit = nowLvl[c] && !prevLvl[c];
          2'b01:   hit = !nowLvl[c] && prevLvl[c];
          2'b10:   hit = nowLvl[c] != prevLvl[c];
          default: hit = 1'b0;
        endcase
        pulse = active && hit;
        exp.pulses[c] = pulse;
        if (lat) modelShadow[c] = modelCnt[c];
        if (clr) begin
          modelCnt[c] = 0;
          modelOvf[c] = 1'b0;
        end else if (pulse && curEn) begin
          if (modelCnt[c] == MAXV) begin
            modelOvf[c] = 1'b1;
`ifdef EDGE_COUNTER_SATURATE_EN
            modelCnt[c] = MAXV;
`else
            modelCnt[c] = 0;
`endif
          end else begin
            modelCnt[c] = modelCnt[c] + 1;
          end
        end
      end
      exp.armed = active;
      edgeIdx++;
    end
    for (int c = 0; c < CH; c++) exp.ovf[c] = modelOvf[c];
    exp.count = (int'(curSel) < CH) ? BW'(modelShadow[curSel]) : '0;
    expQ.push_back(exp);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checkCount++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  task automatic pulseChannel(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      curSig[ch] = 1'b1;
      idle(2);
      curSig[ch] = 1'b0;
      idle(2);
    end
  endtask

  task automatic latchAndShow(input int ch);
    idle(SS + 2);
    curSel = SEL_W'(ch);
    applyStimulus(1'b1, 1'b0, 1'b1);
    idle(2);
  endtask

  // Monitor: pops one prediction per rising edge and compares it with what the DUT shows
  initial begin
    expect_t got;
    forever begin
      @(posedge Clk);
      #1;
      if (expQ.size() > 0) begin
        got = expQ.pop_front();
        checkOutput("Pulses",   32'(Pulses),   32'(got.pulses));
        checkOutput("Overflow", 32'(Overflow), 32'(got.ovf));
        checkOutput("Armed",    32'(Armed),    32'(got.armed));
        checkOutput("Count",    32'(Count),    32'(got.count));
      end
    end
  end

  initial begin
    int waitCycles;
    checkCount = 0;
    failCount  = 0;
    edgeIdx    = 0;
    curSig     = '1;
    curMode    = 2'b00;
    curEn      = 1'b1;
    curSel     = '0;
    nReset     = 1'b0;
    Signals    = curSig;
    EdgeMode   = curMode;
    Enable     = curEn;
    Clear      = 1'b0;
    Latch      = 1'b0;
    Sel        = curSel;
    for (int c = 0; c < CH; c++) begin
      modelCnt[c]    = 0;
      modelOvf[c]    = 1'b0;
      modelShadow[c] = 0;
    end

    $display("[TB] reset with all inputs high");
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    idle(SS + 4);
    latchAndShow(0);
    curSig = '0;
    idle(SS + 3);

    $display("[TB] five rising pulses on ch1, rising then both-edge mode");
    applyStimulus(1'b1, 1'b1, 1'b0);
    pulseChannel(1, 5);
    latchAndShow(1);
    latchAndShow(0);
    curMode = 2'b10;
    applyStimulus(1'b1, 1'b1, 1'b0);
    pulseChannel(1, 5);
    latchAndShow(1);

    $display("[TB] overflow on ch0");
    curMode = 2'b00;
    applyStimulus(1'b1, 1'b1, 1'b0);
    pulseChannel(0, 16);
    latchAndShow(0);
    pulseChannel(0, 2);
    latchAndShow(0);

    $display("[TB] edge, clear and latch together at count 7");
    applyStimulus(1'b1, 1'b1, 1'b0);
    pulseChannel(0, 7);
    idle(SS + 2);
    curSel    = '0;
    curSig[0] = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(SS - 1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    idle(3);
    curSig[0] = 1'b0;
    latchAndShow(0);

    $display("[TB] enable low, then detection off");
    curEn = 1'b0;
    pulseChannel(3, 3);
    latchAndShow(3);
    curEn   = 1'b1;
    curMode = 2'b11;
    pulseChannel(3, 3);
    latchAndShow(3);
    curMode = 2'b00;

    $display("[TB] reset mid-count at 9");
    pulseChannel(2, 9);
    idle(SS + 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    idle(SS + 4);
    latchAndShow(2);
    curSel = 3'd6;
    idle(2);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      logic rstN;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(3) == 0) curSig[c] = ~curSig[c];
      end
      if ($urandom_range(19) == 0) curMode = 2'($urandom_range(3));
      curEn  = ($urandom_range(7) != 0);
      curSel = SEL_W'($urandom_range(7));
      rstN   = ($urandom_range(149) != 0);
      applyStimulus(rstN, ($urandom_range(39) == 0), ($urandom_range(3) == 0));
    end

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 20) begin
      @(posedge Clk);
      waitCycles++;
    end
    #2;
    if (expQ.size() > 0) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL drain: %0d predictions left, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
